fc_layer_seq: RTL and testbench
===============================

# fc_layer_seq

Parametrised, sequential fully-connected layer for the MLP datapath. Processes one input node per cycle, broadcasting it to OUTPUT_NODES signed multiply-accumulate lanes. Each lane pairs that input with its weight from an external synchronous weight memory addressed by this block. After the last input, it quantises and saturates the accumulators and presents the layer result under a valid/ready handshake. It replaces the free-running layer-1 engine and chains layer to layer via start/out_valid.

## Interface
- DATA_WIDTH, 8: signed input, weight and output element width
- ACC_WIDTH, 24: signed accumulator width; must be ≥ 2*DATA_WIDTH + ADDR_WIDTH
- INPUT_NODES, 24: inputs per inference, equal to the number of weight rows
- OUTPUT_NODES, 128: number of MAC lanes / outputs
- ADDR_WIDTH, 5: weight address width, ≥ clog2(INPUT_NODES)
- SHIFT, 0: arithmetic right shift applied to each accumulator before saturation
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  request a new inference; sampled only when accepted (see Operation)
- input_fc  in  DATA_WIDTH*INPUT_NODES  input vector; node k at bits [DATA_WIDTH*k +: DATA_WIDTH]; latched on start acceptance
- weight_addr  out  ADDR_WIDTH  weight row address
- weight_rd_en  out  1  read strobe for weight_addr
- weights  in  DATA_WIDTH*OUTPUT_NODES  weight row, valid one cycle after weight_rd_en; lane i at [DATA_WIDTH*i +: DATA_WIDTH]
- busy  out  1  high in RUN, DRAIN and OUT
- out_valid  out  1  output_fc holds a finished result
- out_ready  in  1  consumer accepts the result
- output_fc  out  DATA_WIDTH*OUTPUT_NODES  quantised results, lane i as for weights

## Operation
- Reset values: state IDLE, weight_addr 0, weight_rd_en 0, busy 0, out_valid 0, output_fc 0, all accumulators 0.
- FSM has four states: IDLE, RUN, DRAIN and OUT.
  - IDLE to RUN on start: latch input_fc and clear the accumulators.
  - RUN: weight_rd_en=1 and weight_addr counts 0..INPUT_NODES-1, one per cycle. After the count reaches INPUT_NODES-1 the FSM goes to DRAIN, and weight_addr wraps to 0.
  - DRAIN: weight_rd_en=0; the final MAC completes.
  - OUT: out_valid=1 and output_fc is held stable until out_ready.
  - OUT to IDLE on out_ready & !start. OUT to RUN on out_ready & start, which is a back-to-back accept.
- start is ignored in RUN and DRAIN, and in OUT while out_ready=0.
- MAC: acc_i += input[k] * weights_i, where the weights arrived for address k. input[k] is delayed one cycle to align with the memory latency. The product is a full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH.
- Quantise on the DRAIN→OUT transition: q = acc >>> SHIFT, then clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Reset mid-operation aborts immediately to the reset values. No partial result is ever flagged valid.

## Timing
- start sampled at edge T0.
- weight_addr=k and weight_rd_en=1 during cycle T0+1+k.
- Weights for row k are valid during cycle T0+2+k, and the MAC registers at edge T0+2+k+1.
- out_valid rises INPUT_NODES+2 cycles after T0. It falls in the cycle after an out_ready-high edge, unless a back-to-back start was accepted, in which case busy stays high.
- Throughput is one inference per INPUT_NODES+2 cycles with out_ready tied high.

## Configuration
- FC_RELU_EN defined: after saturation, negative results are forced to 0, so outputs lie in [0, 2^(DATA_WIDTH-1)-1].
- FC_RELU_EN undefined: signed saturated outputs pass unchanged.

## Structure
- Shared package fc_pkg holds:
  - the FSM state encoding (IDLE, RUN, DRAIN, OUT)
  - default DATA_WIDTH and ACC_WIDTH constants
  - the saturate/ReLU function shared by all layer instances
- One sub-module, fc_mac_lane: a single signed MAC with synchronous clear, accumulate enable and quantise/saturate output. It is instantiated OUTPUT_NODES times by generate.

## Test plan
- Reset: assert reset mid-idle → all outputs 0, weight_addr 0. Then run INPUT_NODES=24 with inputs 1 and weights 1 → all 128 outputs 24, and out_valid rises 26 cycles after start.
- INPUT_NODES=4, OUTPUT_NODES=2, inputs {1,2,3,4} (node 0..3), lane0 weights {1,1,1,1}, lane1 {1,0,0,-1} → outputs 10 and -3. weight_addr sequence is 0,1,2,3.
- Saturation, INPUT_NODES=4, SHIFT=0:
  - inputs 127, weights 127 → output 127.
  - inputs -128, weights 127 → -128 without FC_RELU_EN, 0 with it.
  - With SHIFT=8, inputs 16, weights 16 → 4.
- Backpressure: out_ready low for 10 cycles in OUT → output_fc stable, out_valid held, start pulses ignored. Then out_ready=1 with start=1 in the same cycle → RUN begins next cycle with the new input_fc, no IDLE cycle.
- Reset asserted while weight_addr=2 in RUN → immediate IDLE, out_valid 0, accumulators 0. A subsequent start reproduces the correct result from the second scenario.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: FSM state encoding, default element widths and the output saturate/ReLU helper.
// Compile-time option FC_RELU_EN: clamp negative layer outputs to zero after saturation.
package fc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ACC_WIDTH  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fc_state_t;

  // Clamp a shifted accumulator into the signed dw-bit output range.
  function automatic longint fc_saturate(input longint val, input int dw);
    longint hi;
    longint lo;
    hi = (longint'(1) << (dw - 1)) - 1;
`ifdef FC_RELU_EN
    lo = 0;
`else
    lo = -(longint'(1) << (dw - 1));
`endif
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one signed multiply-accumulate lane with synchronous clear and a
// quantised/saturated output register loaded from the accumulator's next value.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         load,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] q
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_reg;
  logic signed [ACC_WIDTH-1:0]    acc_next;
  logic signed [ACC_WIDTH-1:0]    acc_shr;
  logic signed [DATA_WIDTH-1:0]   q_reg;

  assign prod = a * b;

  always_comb begin
    acc_next = acc_reg;
    if (clr) begin
      acc_next = '0;
    end else if (en) begin
      acc_next = acc_reg + ACC_WIDTH'(prod);
    end
  end

  // The final MAC lands on the same edge as the load, so quantise the next value.
  assign acc_shr = acc_next >>> SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
      q_reg   <= '0;
    end else begin
      acc_reg <= acc_next;
      if (load) begin
        q_reg <= DATA_WIDTH'(fc_saturate(64'(acc_shr), DATA_WIDTH));
      end
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully-connected layer, one input node per cycle broadcast to
// OUTPUT_NODES MAC lanes; result offered under out_valid/out_ready. Option: FC_RELU_EN.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH    = DEFAULT_ACC_WIDTH,
  parameter int INPUT_NODES  = 24,
  parameter int OUTPUT_NODES = 128,
  parameter int ADDR_WIDTH   = 5,
  parameter int SHIFT        = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0]  input_fc,
  output logic [ADDR_WIDTH-1:0]              weight_addr,
  output logic                               weight_rd_en,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc
);

  fc_state_t                    state_reg;
  fc_state_t                    state_next;
  logic [ADDR_WIDTH-1:0]        addr_reg;
  logic [ADDR_WIDTH-1:0]        addr_next;
  logic signed [DATA_WIDTH-1:0] in_mem_reg [INPUT_NODES];
  logic signed [DATA_WIDTH-1:0] in_d_reg;
  logic                         mac_en_reg;
  logic                         accept;
  logic                         load;
  logic                         last_addr;

  assign last_addr = (addr_reg == ADDR_WIDTH'(INPUT_NODES - 1));

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    accept     = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
          addr_next  = '0;
        end
      end
      RUN: begin
        if (last_addr) begin
          state_next = DRAIN;
          addr_next  = '0;
        end else begin
          addr_next = addr_reg + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        state_next = OUT;
        load       = 1'b1;
      end
      OUT: begin
        // Accepting a new start here skips IDLE entirely.
        if (out_ready) begin
          if (start) begin
            accept     = 1'b1;
            state_next = RUN;
            addr_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // in_d_reg and mac_en_reg trail the address by one cycle to meet the weight read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      mac_en_reg <= 1'b0;
      in_d_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      mac_en_reg <= (state_reg == RUN);
      in_d_reg   <= in_mem_reg[addr_reg];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_NODES; gi++) begin : g_in
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_mem_reg[gi] <= '0;
        end else if (accept) begin
          in_mem_reg[gi] <= input_fc[DATA_WIDTH*gi +: DATA_WIDTH];
        end
      end
    end

    for (gi = 0; gi < OUTPUT_NODES; gi++) begin : g_lane
      fc_mac_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT)
      ) u_lane (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .en   (mac_en_reg),
        .load (load),
        .a    (in_d_reg),
        .b    (weights[DATA_WIDTH*gi +: DATA_WIDTH]),
        .q    (output_fc[DATA_WIDTH*gi +: DATA_WIDTH])
      );
    end
  endgenerate

  assign weight_addr  = addr_reg;
  assign weight_rd_en = (state_reg == RUN);
  assign busy         = (state_reg != IDLE);
  assign out_valid    = (state_reg == OUT);

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: directed checks of three fc_layer_seq configurations (24x128, 4x2, 4x2 with SHIFT=8)
// against hand-computed results; each DUT reads a registered weight memory model.
module tb_fc_layer_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint relu_exp(input longint v);
    return (RELU && v < 0) ? 0 : v;
  endfunction

  // ---------------- DUT A: 24 inputs x 128 lanes ----------------
  logic              start_a, rd_en_a, busy_a, valid_a, ready_a;
  logic [8*24-1:0]   in_a;
  logic [4:0]        addr_a;
  logic [8*128-1:0]  w_a, out_a;

  fc_layer_seq dut_a (
    .clk(clk), .reset(reset), .start(start_a), .input_fc(in_a),
    .weight_addr(addr_a), .weight_rd_en(rd_en_a), .weights(w_a),
    .busy(busy_a), .out_valid(valid_a), .out_ready(ready_a), .output_fc(out_a)
  );
  always @(posedge clk) w_a <= rd_en_a ? {128{8'd1}} : '0;

  // ---------------- DUT B: 4 inputs x 2 lanes ----------------
  logic              start_b, rd_en_b, busy_b, valid_b, ready_b;
  logic [31:0]       in_b;
  logic [1:0]        addr_b;
  logic [15:0]       w_b, out_b;
  logic signed [7:0] wb0 [4];
  logic signed [7:0] wb1 [4];
  int                addr_log_b[$];

  fc_layer_seq #(.DATA_WIDTH(8), .ACC_WIDTH(24), .INPUT_NODES(4), .OUTPUT_NODES(2),
                 .ADDR_WIDTH(2), .SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .input_fc(in_b),
    .weight_addr(addr_b), .weight_rd_en(rd_en_b), .weights(w_b),
    .busy(busy_b), .out_valid(valid_b), .out_ready(ready_b), .output_fc(out_b)
  );
  always @(posedge clk) w_b <= rd_en_b ? {wb1[addr_b], wb0[addr_b]} : '0;

  // ---------------- DUT C: 4 inputs x 2 lanes, SHIFT=8 ----------------
  logic              start_c, rd_en_c, busy_c, valid_c, ready_c;
  logic [31:0]       in_c;
  logic [1:0]        addr_c;
  logic [15:0]       w_c, out_c;

  fc_layer_seq #(.DATA_WIDTH(8), .ACC_WIDTH(24), .INPUT_NODES(4), .OUTPUT_NODES(2),
                 .ADDR_WIDTH(2), .SHIFT(8)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .input_fc(in_c),
    .weight_addr(addr_c), .weight_rd_en(rd_en_c), .weights(w_c),
    .busy(busy_c), .out_valid(valid_c), .out_ready(ready_c), .output_fc(out_c)
  );
  always @(posedge clk) w_c <= rd_en_c ? {2{8'd16}} : '0;

  function automatic longint lane_a(input int i);
    return longint'($signed(out_a[8*i +: 8]));
  endfunction
  function automatic longint lane_b(input int i);
    return longint'($signed(out_b[8*i +: 8]));
  endfunction
  function automatic longint lane_c(input int i);
    return longint'($signed(out_c[8*i +: 8]));
  endfunction

  // Called at the negedge of cycle T0+1; returns with lat = cycles since T0 at out_valid.
  task automatic wait_b(output int lat);
    lat = 1;
    addr_log_b.delete();
    while (!valid_b && lat < 60) begin
      if (rd_en_b) addr_log_b.push_back(int'(addr_b));
      @(negedge clk);
      lat++;
    end
    if (!valid_b) check("b_timeout", 0, 1);
  endtask

  task automatic run_b(input logic [31:0] x, output int lat);
    @(negedge clk);
    in_b    = x;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_b(lat);
  endtask

  task automatic release_b();
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    check("b_valid_drop", valid_b, 0);
  endtask

  task automatic set_wb(input logic [31:0] l0, input logic [31:0] l1);
    for (int k = 0; k < 4; k++) begin
      wb0[k] = l0[8*k +: 8];
      wb1[k] = l1[8*k +: 8];
    end
  endtask

  initial begin
    int lat;
    reset   = 1'b1;
    start_a = 0; ready_a = 0; in_a = '0;
    start_b = 0; ready_b = 0; in_b = '0;
    start_c = 0; ready_c = 0; in_c = '0;
    set_wb(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted while idle
    reset = 1'b1;
    @(negedge clk);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rd_en", rd_en_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_out_nonzero", |out_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // 24 x 128, all ones
    in_a    = {24{8'd1}};
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1;
    while (!valid_a && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("a_latency", lat, 26);
    for (int i = 0; i < 128; i++) check($sformatf("a_lane%0d", i), lane_a(i), 24);
    $display("[TB] full layer: lat=%0d lane0=%0d lane127=%0d", lat, lane_a(0), lane_a(127));
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    check("a_valid_drop", valid_a, 0);

    // 4 x 2 dot products, then backpressure
    set_wb({8'd1, 8'd1, 8'd1, 8'd1}, {8'hFF, 8'd0, 8'd0, 8'd1});
    run_b({8'd4, 8'd3, 8'd2, 8'd1}, lat);
    check("b_latency", lat, 6);
    check("b_lane0", lane_b(0), 10);
    check("b_lane1", lane_b(1), relu_exp(-3));
    check("b_addr_count", addr_log_b.size(), 4);
    for (int k = 0; k < 4 && k < addr_log_b.size(); k++) check($sformatf("b_addr%0d", k), addr_log_b[k], k);
    $display("[TB] dot: lat=%0d lane0=%0d lane1=%0d", lat, lane_b(0), lane_b(1));

    for (int c = 0; c < 10; c++) begin
      start_b = c[0];
      in_b    = {4{8'd9}};
      @(negedge clk);
      check("bp_valid", valid_b, 1);
      check("bp_lane0", lane_b(0), 10);
      check("bp_lane1", lane_b(1), relu_exp(-3));
    end
    $display("[TB] backpressure: 10 cycles held, valid=%0d", valid_b);

    // Back-to-back accept
    ready_b = 1'b1;
    start_b = 1'b1;
    in_b    = {4{8'd1}};
    @(negedge clk);
    ready_b = 1'b0;
    start_b = 1'b0;
    check("b2b_rd_en", rd_en_b, 1);
    check("b2b_addr", addr_b, 0);
    check("b2b_valid", valid_b, 0);
    check("b2b_busy", busy_b, 1);
    wait_b(lat);
    check("b2b_latency", lat, 6);
    check("b2b_lane0", lane_b(0), 4);
    check("b2b_lane1", lane_b(1), 0);
    $display("[TB] back-to-back: lat=%0d lane0=%0d lane1=%0d", lat, lane_b(0), lane_b(1));
    release_b();

    // Positive saturation
    set_wb({4{8'd127}}, {4{8'd127}});
    run_b({4{8'd127}}, lat);
    check("sat_pos_lane0", lane_b(0), 127);
    check("sat_pos_lane1", lane_b(1), 127);
    $display("[TB] sat pos: lane0=%0d lane1=%0d", lane_b(0), lane_b(1));
    release_b();

    // Negative saturation
    run_b({4{8'h80}}, lat);
    check("sat_neg_lane0", lane_b(0), relu_exp(-128));
    check("sat_neg_lane1", lane_b(1), relu_exp(-128));
    $display("[TB] sat neg: lane0=%0d lane1=%0d", lane_b(0), lane_b(1));
    release_b();

    // SHIFT=8: 4*16*16 = 1024, >>8 = 4
    @(negedge clk);
    in_c    = {4{8'd16}};
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    lat = 1;
    while (!valid_c && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("shift_latency", lat, 6);
    check("shift_lane0", lane_c(0), 4);
    check("shift_lane1", lane_c(1), 4);
    $display("[TB] shift: lane0=%0d lane1=%0d", lane_c(0), lane_c(1));
    ready_c = 1'b1;
    @(negedge clk);
    ready_c = 1'b0;

    // Reset mid-run at weight_addr 2, then rerun the dot product
    set_wb({8'd1, 8'd1, 8'd1, 8'd1}, {8'hFF, 8'd0, 8'd0, 8'd1});
    @(negedge clk);
    in_b    = {8'd4, 8'd3, 8'd2, 8'd1};
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat = 0;
    while (!(rd_en_b && addr_b == 2'd2) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("mid_reached_addr2", addr_b, 2);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", valid_b, 0);
    check("mid_rst_busy", busy_b, 0);
    check("mid_rst_rd_en", rd_en_b, 0);
    check("mid_rst_addr", addr_b, 0);
    check("mid_rst_out", out_b, 0);
    @(negedge clk);
    reset = 1'b0;
    run_b({8'd4, 8'd3, 8'd2, 8'd1}, lat);
    check("rerun_latency", lat, 6);
    check("rerun_lane0", lane_b(0), 10);
    check("rerun_lane1", lane_b(1), relu_exp(-3));
    $display("[TB] rerun after reset: lane0=%0d lane1=%0d", lane_b(0), lane_b(1));
    release_b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
